// File: rtl/iir_mac_pkg.sv
// rtl/iir_mac_pkg.sv - shared types and helpers for the time-multiplexed IIR filter
//
// Purpose: coefficient address map, FSM state encoding and fixed-point helpers
//          used by iir_mac_seq and iir_fixmul.
// Contents:
//   B_BASE     first feed-forward coefficient address (b0)
//   a_base()   first feedback coefficient address (a1) for a given order
//   state_t    FSM states IDLE / MAC / WB
//   frac_bits  fractional bit count of the Q2.(CW-2) format
package iir_mac_pkg;

  localparam int B_BASE = 0;

  // a1 sits right after bORDER in the coefficient table.
  function automatic int a_base(input int order);
    return order + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic int frac_bits(input int cw);
    return cw - 2;
  endfunction

endpackage

// File: rtl/iir_fixmul.sv
// rtl/iir_fixmul.sv - combinational Q2.(CW-2) signed multiplier
//
// Purpose: full-precision signed multiply, renormalised back to Q2.(CW-2).
//          The product sign is kept, the two redundant integer bits below it
//          are dropped and the fraction is truncated, so overflow wraps.
// Ports:
//   a_i  in  CW  multiplicand, Q2.(CW-2)
//   b_i  in  CW  multiplier,   Q2.(CW-2)
//   p_o  out CW  product,      Q2.(CW-2)
module iir_fixmul
  import iir_mac_pkg::*;
#(
  parameter int CW = 18
) (
  input  logic signed [CW-1:0] a_i,
  input  logic signed [CW-1:0] b_i,
  output logic signed [CW-1:0] p_o
);

  localparam int FB = frac_bits(CW);

  logic signed [2*CW-1:0] prod;
  logic                   unused_bits;

  assign prod = a_i * b_i;
  assign p_o  = {prod[2*CW-1], prod[2*CW-4:FB]};

  // Dropped integer bits and truncated fraction are intentionally discarded.
  assign unused_bits = ^{prod[2*CW-2:2*CW-3], prod[FB-1:0]};

endmodule

// File: rtl/iir_mac_seq.sv
// rtl/iir_mac_seq.sv - multi-channel time-multiplexed Direct Form I IIR filter
//
// Purpose: each rising edge of lr_clk filters one sample per channel using one
//          shared multiply-accumulate unit sequenced by an IDLE/MAC/WB FSM.
//          Coefficients are double-buffered (shadow written any time, copied
//          to the active bank only while idle). Feedback coefficients are
//          stored pre-negated, so y = sum(b_k*x[n-k]) + sum(a_k*y[n-k]).
// Configuration: define IIR_MAC_SATURATE_EN to clamp the accumulator and the
//          writeback shift; undefined, both wrap in two's complement.
// Ports:
//   state_clk    in  1       processing clock
//   reset        in  1       synchronous, active-high
//   lr_clk       in  1       sample clock, rising edge starts a frame
//   audio_in     in  NCH*DW  channel c at [c*DW +: DW]
//   audio_out    out NCH*DW  filtered samples, same packing
//   out_valid    out 1       one-cycle pulse after the last channel writeback
//   busy         out 1       frame in progress
//   overrun      out 1       sticky, lr_clk edge seen while busy
//   scale        in  3       left shift applied at writeback
//   coef_we      in  1       shadow bank write strobe
//   coef_addr    in  4       0..ORDER = b0..bORDER, ORDER+1..2*ORDER = a1..aORDER
//   coef_wdata   in  CW      coefficient, Q2.(CW-2)
//   coef_commit  in  1       request shadow-to-active copy
module iir_mac_seq
  import iir_mac_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 18,
  parameter int ORDER = 4,
  parameter int NCH   = 2
) (
  input  logic                  state_clk,
  input  logic                  reset,
  input  logic                  lr_clk,
  input  logic [NCH*DW-1:0]     audio_in,
  output logic [NCH*DW-1:0]     audio_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic [2:0]            scale,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  logic [CW-1:0]         coef_wdata,
  input  logic                  coef_commit
);

  localparam int NCOEF  = 2 * ORDER + 1;
  localparam int A_BASE = a_base(ORDER);
  localparam int KW     = 5;
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic signed [CW-1:0] SAT_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {1'b1, {(CW-1){1'b0}}};

  state_t                 state_q, state_d;
  logic                   lr_q;
  logic [KW-1:0]          k_q;
  logic [CHW-1:0]         ch_q;
  logic signed [CW-1:0]   acc_q, acc_d;
  logic [NCH*DW-1:0]      in_q;
  logic [NCH*DW-1:0]      audio_out_q;
  logic                   out_valid_q;
  logic                   overrun_q;
  logic                   commit_pend_q;

  logic signed [CW-1:0]   shadow_q [NCOEF];
  logic signed [CW-1:0]   active_q [NCOEF];
  logic signed [CW-1:0]   x_hist_q [NCH][ORDER];
  logic signed [CW-1:0]   y_hist_q [NCH][ORDER];

  logic                   start;
  logic                   last_ch;
  logic                   last_k;
  logic                   frame_start;
  logic                   copy_now;
  logic                   mac_en;
  logic                   wb_en;

  logic [DW-1:0]          ch_in;
  logic signed [CW-1:0]   xn;
  logic signed [CW-1:0]   opnd;
  logic signed [CW-1:0]   coef_sel;
  logic signed [CW-1:0]   prod;
  logic [CW+7:0]          wide;
  logic signed [CW-1:0]   y_wb;

  assign start   = lr_clk & ~lr_q;
  assign last_ch = (ch_q == CHW'(NCH - 1));
  assign last_k  = (k_q == KW'(NCOEF - 1));

  // FSM state register
  always_ff @(posedge state_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = MAC;
      MAC:     if (last_k) state_d = WB;
      WB:      state_d = last_ch ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs / datapath controls
  always_comb begin
    frame_start = 1'b0;
    copy_now    = 1'b0;
    mac_en      = 1'b0;
    wb_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        frame_start = start;
        // A commit coinciding with start is applied now so the new frame
        // already sees it on its first MAC.
        copy_now    = commit_pend_q | (coef_commit & start);
      end
      MAC:     mac_en = 1'b1;
      WB:      wb_en  = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign audio_out = audio_out_q;

  // Operand and coefficient selection for the current tap k of channel ch
  always_comb begin
    ch_in = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == CHW'(c)) ch_in = in_q[c*DW +: DW];
    end
    xn = {ch_in, {(CW-DW){1'b0}}};

    opnd = xn;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < ORDER; i++) begin
        if (ch_q == CHW'(c) && k_q == KW'(B_BASE + 1 + i)) opnd = x_hist_q[c][i];
        if (ch_q == CHW'(c) && k_q == KW'(A_BASE + i))     opnd = y_hist_q[c][i];
      end
    end

    coef_sel = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (k_q == KW'(i)) coef_sel = active_q[i];
    end
  end

  iir_fixmul #(.CW(CW)) u_mul (
    .a_i (coef_sel),
    .b_i (opnd),
    .p_o (prod)
  );

`ifdef IIR_MAC_SATURATE_EN
  logic signed [CW:0] sum_w;

  always_comb begin
    sum_w = {acc_q[CW-1], acc_q} + {prod[CW-1], prod};
    if (sum_w[CW] != sum_w[CW-1]) acc_d = sum_w[CW] ? SAT_MIN : SAT_MAX;
    else                          acc_d = sum_w[CW-1:0];
  end

  // The shift overflows when the bits above the new sign position are not
  // all copies of it; clamp toward the original sign in that case.
  always_comb begin
    wide = {{8{acc_q[CW-1]}}, acc_q} << scale;
    if ((|wide[CW+7:CW-1]) && !(&wide[CW+7:CW-1]))
      y_wb = acc_q[CW-1] ? SAT_MIN : SAT_MAX;
    else
      y_wb = wide[CW-1:0];
  end
`else
  logic unused_wide;

  assign acc_d = acc_q + prod;

  always_comb begin
    wide = {{8{acc_q[CW-1]}}, acc_q} << scale;
    y_wb = wide[CW-1:0];
  end

  assign unused_wide = ^wide[CW+7:CW];
`endif

  // Datapath registers
  always_ff @(posedge state_clk) begin
    if (reset) begin
      lr_q          <= lr_clk;
      k_q           <= '0;
      ch_q          <= '0;
      acc_q         <= '0;
      in_q          <= '0;
      audio_out_q   <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < ORDER; i++) begin
          x_hist_q[c][i] <= '0;
          y_hist_q[c][i] <= '0;
        end
      end
    end else begin
      lr_q        <= lr_clk;
      out_valid_q <= wb_en & last_ch;

      if (start && state_q != IDLE) overrun_q <= 1'b1;

      for (int i = 0; i < NCOEF; i++) begin
        if (coef_we && (int'(coef_addr) == i)) shadow_q[i] <= coef_wdata;
      end

      if (copy_now) begin
        for (int i = 0; i < NCOEF; i++) active_q[i] <= shadow_q[i];
      end
      commit_pend_q <= copy_now ? 1'b0 : (commit_pend_q | coef_commit);

      if (frame_start) begin
        in_q  <= audio_in;
        ch_q  <= '0;
        k_q   <= '0;
        acc_q <= '0;
      end

      if (mac_en) begin
        acc_q <= acc_d;
        k_q   <= k_q + KW'(1);
      end

      if (wb_en) begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_q == CHW'(c)) begin
            x_hist_q[c][0] <= xn;
            y_hist_q[c][0] <= y_wb;
            for (int i = 1; i < ORDER; i++) begin
              x_hist_q[c][i] <= x_hist_q[c][i-1];
              y_hist_q[c][i] <= y_hist_q[c][i-1];
            end
            audio_out_q[c*DW +: DW] <= y_wb[CW-1 -: DW];
          end
        end
        if (!last_ch) begin
          ch_q  <= ch_q + CHW'(1);
          k_q   <= '0;
          acc_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_mac_seq.sv
// tb/tb_iir_mac_seq.sv - scoreboard bench for iir_mac_seq with directed vectors
module tb_iir_mac_seq;

  localparam int DW    = 16;
  localparam int CW    = 18;
  localparam int ORDER = 4;
  localparam int NCH   = 2;

  logic              state_clk = 1'b0;
  logic              reset = 1'b1;
  logic              lr_clk = 1'b0;
  logic [NCH*DW-1:0] audio_in = '0;
  logic [NCH*DW-1:0] audio_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic [2:0]        scale = 3'd0;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = 4'd0;
  logic [CW-1:0]     coef_wdata = '0;
  logic              coef_commit = 1'b0;

  iir_mac_seq #(.DW(DW), .CW(CW), .ORDER(ORDER), .NCH(NCH)) dut (
    .state_clk   (state_clk),
    .reset       (reset),
    .lr_clk      (lr_clk),
    .audio_in    (audio_in),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .scale       (scale),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit)
  );

  always #5 state_clk = ~state_clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nvalid = 0;
  int          busy_cnt = 0;
  int          t_start = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always @(posedge state_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a frame.
  always @(negedge state_clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (out_valid) begin
      nvalid <= nvalid + 1;
      check("out_valid_latency", 32'(cyc - t_start), 32'd21);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("audio_out", audio_out, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge state_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wcoef(input logic [3:0] addr, input logic [CW-1:0] data);
    tick();
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = data;
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic commit();
    tick();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    tick();
    tick();
  endtask

  task automatic expect_out(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    exp_q.push_back({e1, e0});
  endtask

  // Raises lr_clk for three cycles; returns mid-frame (cycle T+3).
  task automatic send(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
    tick();
    audio_in = {s1, s0};
    lr_clk   = 1'b1;
    t_start  = cyc;
    tick();
    tick();
    tick();
    lr_clk   = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    int i;
    n0 = nvalid;
    for (i = 0; i < 60 && nvalid == n0; i++) tick();
    check("frame_done_timeout", 32'(nvalid != n0), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int n0;

    tick();
    tick();
    check("reset_audio_out", audio_out, 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy), 32'd0);
    check("reset_overrun",   32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // Passthrough, plus an out-of-range coefficient write that must be ignored
    wcoef(4'd0, 18'h10000);
    wcoef(4'd15, 18'h3FFFF);
    commit();
    b0 = busy_cnt;
    expect_out(16'h1234, 16'hF000);
    send(16'h1234, 16'hF000);
    wait_done();
    check("busy_cycles", 32'(busy_cnt - b0), 32'd20);

    // One-sample delay with independent channel histories
    do_reset();
    wcoef(4'd1, 18'h10000);
    commit();
    expect_out(16'd0, 16'd0);     send(16'd100, 16'd7); wait_done();
    expect_out(16'd100, 16'd7);   send(16'd200, 16'd8); wait_done();
    expect_out(16'd200, 16'd8);   send(16'd300, 16'd9); wait_done();

    // Feedback with a1 = +0.5
    do_reset();
    wcoef(4'd0, 18'h10000);
    wcoef(4'd5, 18'h08000);
    commit();
    expect_out(16'h4000, 16'h2000); send(16'h4000, 16'h2000); wait_done();
    expect_out(16'h2000, 16'h1000); send(16'h0000, 16'h0000); wait_done();
    expect_out(16'h1000, 16'h0800); send(16'h0000, 16'h0000); wait_done();
    expect_out(16'h0800, 16'h0400); send(16'h0000, 16'h0000); wait_done();

    // Shadow bank: write without commit, then commit mid-frame
    do_reset();
    wcoef(4'd0, 18'h10000);
    commit();
    expect_out(16'h1000, 16'h2000);
    send(16'h1000, 16'h2000);
    wcoef(4'd0, 18'h08000);
    wait_done();
    expect_out(16'h1000, 16'h2000); send(16'h1000, 16'h2000); wait_done();
    expect_out(16'h1000, 16'h2000);
    send(16'h1000, 16'h2000);
    tick();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    wait_done();
    expect_out(16'h0800, 16'h1000); send(16'h1000, 16'h2000); wait_done();

    // Overrun: second edge during the frame is ignored, flag is sticky
    do_reset();
    wcoef(4'd0, 18'h10000);
    commit();
    check("overrun_clear_before", 32'(overrun), 32'd0);
    expect_out(16'h0111, 16'h0222);
    send(16'h0111, 16'h0222);
    tick();
    tick();
    lr_clk = 1'b1;
    tick();
    tick();
    lr_clk = 1'b0;
    wait_done();
    check("overrun_set", 32'(overrun), 32'd1);
    expect_out(16'h0333, 16'h0444); send(16'h0333, 16'h0444); wait_done();
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-MAC aborts the frame and clears history
    do_reset();
    wcoef(4'd0, 18'h10000);
    wcoef(4'd1, 18'h10000);
    commit();
    expect_out(16'h0100, 16'h0200); send(16'h0100, 16'h0200); wait_done();
    send(16'h0AAA, 16'h0BBB);
    tick();
    do_reset();
    check("midreset_audio_out", audio_out, 32'd0);
    check("midreset_busy",      32'(busy), 32'd0);
    check("midreset_overrun",   32'(overrun), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    n0 = nvalid;
    repeat (30) tick();
    check("midreset_no_valid", 32'(nvalid - n0), 32'd0);
    wcoef(4'd0, 18'h10000);
    wcoef(4'd1, 18'h10000);
    commit();
    expect_out(16'h0100, 16'h0200); send(16'h0100, 16'h0200); wait_done();

    // Writeback shift overflow
    do_reset();
    wcoef(4'd0, 18'h10000);
    commit();
    scale = 3'd2;
`ifdef IIR_MAC_SATURATE_EN
    expect_out(16'h7FFF, 16'h0400);
`else
    expect_out(16'hC000, 16'h0400);
`endif
    send(16'h7000, 16'h0100);
    wait_done();
    scale = 3'd0;

    repeat (10) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
